// File: rtl/hazard_sequencer.sv
// Load-use / branch-flush / external-freeze sequencer for the IF/ID -> ID/EX boundary.
// Optional statistics counters are built only when HAZARD_SEQ_STATS_EN is defined.
module hazard_sequencer #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              branch_taken,
  input  logic              ext_stall_req,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_hold,
  output logic [1:0]        seq_state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int MAXC  = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int REM_W = $clog2(MAXC + 1);

  typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2, BAD = 2'd3} state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             hazard, stall_inc, flush_inc;

  assign hazard = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (ext_stall_req) begin
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      case (state_q)
        RUN, LSTALL, FLUSH: begin
          if (branch_taken) begin
            // A taken branch wins everywhere and (re)starts the flush window.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              rem_d   = REM_W'(FLUSH_CYCLES - 1);
            end else begin
              state_d = RUN;
            end
          end else if (state_q == FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (rem_q <= REM_W'(1)) state_d = RUN;
            else                    rem_d   = rem_q - REM_W'(1);
          end else if (state_q == LSTALL || hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            if (state_q == LSTALL) begin
              if (rem_q <= REM_W'(1)) state_d = RUN;
              else                    rem_d   = rem_q - REM_W'(1);
            end else if (LOAD_LAT > 1) begin
              state_d = LSTALL;
              rem_d   = REM_W'(LOAD_LAT - 1);
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
    // Reset overrides the control outputs combinationally.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign seq_state = state_q;

`ifdef HAZARD_SEQ_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_inc;
  assign unused_inc  = stall_inc ^ flush_inc;
  assign stall_count = '0;
  assign flush_count = '0;
`endif
endmodule
